// File: rtl/sparc_exu_ccr_pipe.sv
// Per-thread condition-code pipeline: builds the CCR from ALU flags in E,
// carries it through M and W, commits it to a per-thread register file and
// serves bypassed CCR reads for the instruction in D.
module sparc_exu_ccr_pipe #(
  parameter int NTHR = 4
) (
  input  logic       rclk,
  input  logic       reset,
  input  logic       ecl_ccr_setcc_e,
  input  logic       ecl_ccr_wrccr_e,
  input  logic [7:0] ecl_ccr_wrdata_e,
  input  logic [1:0] ecl_ccr_tid_e,
  input  logic       ecl_ccr_sel_logic_e,
  input  logic       ecl_ccr_sub_e,
  input  logic       alu_ecl_add_n64_e,
  input  logic       alu_ecl_add_n32_e,
  input  logic       alu_ecl_log_n64_e,
  input  logic       alu_ecl_log_n32_e,
  input  logic       alu_ecl_zhigh_e,
  input  logic       alu_ecl_zlow_e,
  input  logic       alu_ecl_cout64_e_l,
  input  logic       alu_ecl_cout32_e,
  input  logic       alu_ecl_adderin2_63_e,
  input  logic       alu_ecl_adderin2_31_e,
  input  logic       byp_ccr_rs1_63_e,
  input  logic       byp_ccr_rs1_31_e,
  input  logic       ecl_ccr_kill_m,
  input  logic       ecl_ccr_kill_w,
  input  logic [1:0] ecl_ccr_rd_tid_d,
  output logic [7:0] ccr_ecl_ccr_e,
  output logic [7:0] ccr_ecl_ccr_w,
  output logic       ccr_ecl_commit_w
);

  logic       valid_e;
  logic [3:0] icc_e, xcc_e;
  logic [7:0] ccr_val_e;

  always_comb begin
    icc_e = '0;
    xcc_e = '0;
    if (ecl_ccr_sel_logic_e) begin
      icc_e = {alu_ecl_log_n32_e, alu_ecl_zlow_e, 2'b00};
      xcc_e = {alu_ecl_log_n64_e, alu_ecl_zlow_e & alu_ecl_zhigh_e, 2'b00};
    end else begin
      // Overflow: operands (post-invert) agree in sign but the sum does not.
      icc_e = {alu_ecl_add_n32_e,
               alu_ecl_zlow_e,
               (byp_ccr_rs1_31_e == alu_ecl_adderin2_31_e) & (alu_ecl_add_n32_e != byp_ccr_rs1_31_e),
               alu_ecl_cout32_e ^ ecl_ccr_sub_e};
      xcc_e = {alu_ecl_add_n64_e,
               alu_ecl_zlow_e & alu_ecl_zhigh_e,
               (byp_ccr_rs1_63_e == alu_ecl_adderin2_63_e) & (alu_ecl_add_n64_e != byp_ccr_rs1_63_e),
               ~alu_ecl_cout64_e_l ^ ecl_ccr_sub_e};
    end
  end

  assign valid_e   = ecl_ccr_setcc_e | ecl_ccr_wrccr_e;
  assign ccr_val_e = ecl_ccr_wrccr_e ? ecl_ccr_wrdata_e : {xcc_e, icc_e};

  logic       valid_m_q, valid_w_q;
  logic [1:0] tid_m_q, tid_w_q;
  logic [7:0] ccr_m_q, ccr_w_q;
  logic       live_m, live_w;

  assign live_m = valid_m_q & ~ecl_ccr_kill_m;
  assign live_w = valid_w_q & ~ecl_ccr_kill_w;

  always_ff @(posedge rclk) begin
    if (reset) begin
      valid_m_q <= 1'b0;
      valid_w_q <= 1'b0;
      tid_m_q   <= '0;
      tid_w_q   <= '0;
      ccr_m_q   <= '0;
      ccr_w_q   <= '0;
    end else begin
      valid_m_q <= valid_e;
      tid_m_q   <= ecl_ccr_tid_e;
      ccr_m_q   <= ccr_val_e;
      valid_w_q <= live_m;
      tid_w_q   <= tid_m_q;
      ccr_w_q   <= ccr_m_q;
    end
  end

  logic [7:0] rf_q [NTHR];

  always_ff @(posedge rclk) begin
    if (reset) begin
      for (int i = 0; i < NTHR; i++) rf_q[i] <= '0;
    end else if (live_w) begin
      rf_q[tid_w_q] <= ccr_w_q;
    end
  end

  // Youngest matching stage wins so back-to-back dependents see fresh flags.
  logic [7:0] rd_d, rd_q;

  always_comb begin
    rd_d = rf_q[ecl_ccr_rd_tid_d];
    if (valid_e && ecl_ccr_tid_e == ecl_ccr_rd_tid_d)
      rd_d = ccr_val_e;
    else if (live_m && tid_m_q == ecl_ccr_rd_tid_d)
      rd_d = ccr_m_q;
    else if (live_w && tid_w_q == ecl_ccr_rd_tid_d)
      rd_d = ccr_w_q;
  end

  always_ff @(posedge rclk) begin
    if (reset) rd_q <= '0;
    else       rd_q <= rd_d;
  end

  assign ccr_ecl_ccr_e    = rd_q;
  assign ccr_ecl_ccr_w    = valid_w_q ? ccr_w_q : 8'h00;
  assign ccr_ecl_commit_w = live_w;

endmodule
